otter_mem_arbiter: RTL and testbench

//  Shares the single main-memory port between the I-cache refill path and the D-cache

---
 rtl/otter_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_otter_mem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter
// Shares the single main-memory port between the I-cache refill path and the
// D-cache refill/writeback path. One line burst runs at a time; read data is
// steered back to whichever cache owns the burst. D-side normally wins, but a
// starvation counter forces an I grant after STARVE_MAX back-to-back D grants
// taken while the I-cache was waiting.
module otter_mem_arbiter #(
  parameter int BURST_LEN  = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  // I-cache refill side
  input  logic                         IC_REQ,
  input  logic [31:0]                  IC_ADDR,
  output logic                         IC_GNT,
  output logic                         IC_RVALID,
  output logic [31:0]                  IC_RDATA,
  output logic                         IC_DONE,
  // D-cache refill / writeback side
  input  logic                         DC_REQ,
  input  logic                         DC_WE,
  input  logic [31:0]                  DC_ADDR,
  input  logic [31:0]                  DC_WDATA,
  output logic [$clog2(BURST_LEN)-1:0] DC_WIDX,
  output logic                         DC_GNT,
  output logic                         DC_RVALID,
  output logic [31:0]                  DC_RDATA,
  output logic                         DC_DONE,
  // main memory port
  output logic                         MEM_REQ,
  output logic                         MEM_WE,
  output logic [31:0]                  MEM_ADDR,
  output logic [31:0]                  MEM_WDATA,
  input  logic                         MEM_READY,
  input  logic                         MEM_RVALID,
  input  logic [31:0]                  MEM_RDATA
);

  localparam int IW = $clog2(BURST_LEN);
  // One extra bit so a completed burst count (BURST_LEN) is representable.
  localparam int CW = IW + 1;
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [31:0] LINE_MASK = 32'(BURST_LEN * 4 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_I_RD,
    S_D_RD,
    S_D_WR,
    S_FIN
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_issued;
  logic [CW-1:0]   r_returned;
  logic [SW-1:0]   r_starve;
  logic [31:0]     r_base;
  logic            r_side_d;

  logic            w_burst;
  logic            w_rd_burst;
  logic            w_issue_pending;
  logic            w_accept;
  logic            w_d_wins;
  logic            w_last_issue;
  logic            w_last_return;
  logic [31:0]     w_beat_addr;
  logic [SW-1:0]   w_starve_inc;

  assign w_burst         = (r_state == S_I_RD) || (r_state == S_D_RD) || (r_state == S_D_WR);
  assign w_rd_burst      = (r_state == S_I_RD) || (r_state == S_D_RD);
  assign w_issue_pending = w_burst && (r_issued != CW'(BURST_LEN));
  assign w_accept        = w_issue_pending && MEM_READY;
  assign w_last_issue    = (r_issued == CW'(BURST_LEN - 1));
  assign w_last_return   = (r_returned == CW'(BURST_LEN - 1));
  assign w_beat_addr     = r_base + 32'({r_issued, 2'b00});
  // D wins an IDLE arbitration unless the I side has waited out its quota.
  assign w_d_wins        = DC_REQ && !(IC_REQ && (r_starve == SW'(STARVE_MAX)));
  assign w_starve_inc    = (r_starve == SW'(STARVE_MAX)) ? r_starve : r_starve + SW'(1);

  // State register; reset aborts any burst without a DONE pulse.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode and all port outputs (steering of read data is combinational).
  always_comb begin
    w_next_state = r_state;
    IC_GNT       = 1'b0;
    IC_RVALID    = 1'b0;
    IC_RDATA     = '0;
    IC_DONE      = 1'b0;
    DC_GNT       = 1'b0;
    DC_RVALID    = 1'b0;
    DC_RDATA     = '0;
    DC_DONE      = 1'b0;
    DC_WIDX      = '0;
    MEM_REQ      = 1'b0;
    MEM_WE       = 1'b0;
    MEM_ADDR     = '0;
    MEM_WDATA    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_d_wins)    w_next_state = DC_WE ? S_D_WR : S_D_RD;
        else if (IC_REQ) w_next_state = S_I_RD;
      end
      S_I_RD: begin
        IC_GNT    = 1'b1;
        MEM_REQ   = w_issue_pending;
        MEM_ADDR  = w_beat_addr;
        IC_RVALID = MEM_RVALID;
        IC_RDATA  = MEM_RVALID ? MEM_RDATA : '0;
        if (MEM_RVALID && w_last_return) w_next_state = S_FIN;
      end
      S_D_RD: begin
        DC_GNT    = 1'b1;
        MEM_REQ   = w_issue_pending;
        MEM_ADDR  = w_beat_addr;
        DC_RVALID = MEM_RVALID;
        DC_RDATA  = MEM_RVALID ? MEM_RDATA : '0;
        if (MEM_RVALID && w_last_return) w_next_state = S_FIN;
      end
      S_D_WR: begin
        DC_GNT    = 1'b1;
        MEM_REQ   = w_issue_pending;
        MEM_WE    = 1'b1;
        MEM_ADDR  = w_beat_addr;
        MEM_WDATA = DC_WDATA;
        DC_WIDX   = r_issued[IW-1:0];
        if (w_accept && w_last_issue) w_next_state = S_FIN;
      end
      S_FIN: begin
        IC_DONE      = !r_side_d;
        DC_DONE      = r_side_d;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Beat counters, granted side and starvation counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_issued   <= '0;
      r_returned <= '0;
      r_starve   <= '0;
      r_side_d   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_issued   <= '0;
      r_returned <= '0;
      if (w_d_wins) begin
        r_side_d <= 1'b1;
        r_starve <= IC_REQ ? w_starve_inc : '0;
      end else begin
        r_starve <= '0;
        if (IC_REQ) r_side_d <= 1'b0;
      end
    end else begin
      if (w_accept)                r_issued   <= r_issued + CW'(1);
      if (w_rd_burst && MEM_RVALID) r_returned <= r_returned + CW'(1);
    end
  end

  // Line base address captured from the winning side while idle.
  always_ff @(posedge CLK) begin
    if (r_state == S_IDLE) r_base <= w_d_wins ? (DC_ADDR & ~LINE_MASK) : (IC_ADDR & ~LINE_MASK);
  end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb_otter_mem_arbiter
// Directed bench with an in-order memory model, a transaction-level reference
// model of the arbiter checked every cycle, and literal expectations per scenario.
module tb_otter_mem_arbiter;

  localparam int BL  = 8;
  localparam int SM  = 4;
  localparam int IW  = $clog2(BL);
  localparam int LAT = 2;
  localparam logic [31:0] LMASK = 32'(BL * 4 - 1);

  logic          CLK = 1'b0;
  logic          RST;
  logic          IC_REQ, IC_GNT, IC_RVALID, IC_DONE;
  logic [31:0]   IC_ADDR, IC_RDATA;
  logic          DC_REQ, DC_WE, DC_GNT, DC_RVALID, DC_DONE;
  logic [31:0]   DC_ADDR, DC_WDATA, DC_RDATA;
  logic [IW-1:0] DC_WIDX;
  logic          MEM_REQ, MEM_WE, MEM_READY, MEM_RVALID;
  logic [31:0]   MEM_ADDR, MEM_WDATA, MEM_RDATA;

  // The D-cache supplies the writeback word for the requested index combinationally.
  assign DC_WDATA = 32'hCAFE_0000 | 32'(DC_WIDX);

  otter_mem_arbiter #(.BURST_LEN(BL), .STARVE_MAX(SM)) dut (
    .CLK(CLK), .RST(RST),
    .IC_REQ(IC_REQ), .IC_ADDR(IC_ADDR), .IC_GNT(IC_GNT), .IC_RVALID(IC_RVALID),
    .IC_RDATA(IC_RDATA), .IC_DONE(IC_DONE),
    .DC_REQ(DC_REQ), .DC_WE(DC_WE), .DC_ADDR(DC_ADDR), .DC_WDATA(DC_WDATA),
    .DC_WIDX(DC_WIDX), .DC_GNT(DC_GNT), .DC_RVALID(DC_RVALID), .DC_RDATA(DC_RDATA),
    .DC_DONE(DC_DONE),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_READY(MEM_READY), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } rd_t;
  rd_t  rdq[$];
  int   ready_mode = 0;
  logic spur_rv    = 1'b0;

  initial begin
    rd_t r;
    MEM_READY  = 1'b1;
    MEM_RVALID = 1'b0;
    MEM_RDATA  = '0;
    forever begin
      @(negedge CLK);
      if (RST === 1'b1) rdq.delete();
      else if (MEM_REQ === 1'b1 && MEM_READY && MEM_WE === 1'b0)
        rdq.push_back('{MEM_ADDR, cyc + LAT});
      @(posedge CLK);
      #2;
      MEM_RVALID = 1'b0;
      MEM_RDATA  = '0;
      if (rdq.size() > 0 && rdq[0].due <= cyc) begin
        r          = rdq.pop_front();
        MEM_RVALID = 1'b1;
        MEM_RDATA  = memdata(r.addr);
      end else if (spur_rv) begin
        MEM_RVALID = 1'b1;
        MEM_RDATA  = 32'hDEAD_BEEF;
      end
      MEM_READY = (ready_mode == 1) ? cyc[0] : 1'b1;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  bit          mon_en = 1'b0;
  int          m_phase = 0;      // 0 waiting for a grant, 1 burst in flight, 2 completion cycle
  bit          m_d, m_we;
  logic [31:0] m_base;
  int          m_acc, m_ret, m_starve = 0;

  logic [31:0] acc_addr[$];
  logic [31:0] acc_wdata[$];
  int          acc_widx[$];
  int          acc_we_cnt, ic_rv_cnt, dc_rv_cnt, ic_done_cnt, dc_done_cnt;
  int          last_ic_rv_cyc, ic_done_cyc;
  string       grant_log;
  logic        prev_ic_gnt = 1'b0, prev_dc_gnt = 1'b0;

  initial begin
    bit e_ig, e_dg, e_req, e_irv, e_drv;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        e_ig  = (m_phase == 1) && !m_d;
        e_dg  = (m_phase == 1) && m_d;
        e_req = (m_phase == 1) && (m_acc < BL);
        e_irv = e_ig && MEM_RVALID;
        e_drv = e_dg && !m_we && MEM_RVALID;
        chk("IC_GNT", IC_GNT, e_ig);
        chk("DC_GNT", DC_GNT, e_dg);
        chk("MEM_REQ", MEM_REQ, e_req);
        chk("MEM_WE", MEM_WE, (m_phase == 1) && m_we);
        if (e_req) chk("MEM_ADDR", MEM_ADDR, m_base + 32'(4 * m_acc));
        if (m_phase == 1 && m_we) begin
          chk("DC_WIDX", 32'(DC_WIDX), 32'(m_acc));
          chk("MEM_WDATA", MEM_WDATA, DC_WDATA);
        end
        chk("IC_RVALID", IC_RVALID, e_irv);
        chk("DC_RVALID", DC_RVALID, e_drv);
        chk("IC_RDATA", IC_RDATA, e_irv ? memdata(m_base + 32'(4 * m_ret)) : 32'h0);
        chk("DC_RDATA", DC_RDATA, e_drv ? memdata(m_base + 32'(4 * m_ret)) : 32'h0);
        chk("IC_DONE", IC_DONE, (m_phase == 2) && !m_d);
        chk("DC_DONE", DC_DONE, (m_phase == 2) && m_d);

        if (MEM_REQ && MEM_READY) begin
          acc_addr.push_back(MEM_ADDR);
          acc_wdata.push_back(MEM_WDATA);
          acc_widx.push_back(int'(DC_WIDX));
          if (MEM_WE) acc_we_cnt++;
        end
        if (IC_RVALID) begin ic_rv_cnt++; last_ic_rv_cyc = cyc; end
        if (DC_RVALID) dc_rv_cnt++;
        if (IC_DONE) begin ic_done_cnt++; ic_done_cyc = cyc; end
        if (DC_DONE) dc_done_cnt++;
        if (IC_GNT && !prev_ic_gnt) grant_log = {grant_log, "I"};
        if (DC_GNT && !prev_dc_gnt) grant_log = {grant_log, "D"};
        prev_ic_gnt = IC_GNT;
        prev_dc_gnt = DC_GNT;

        if (RST) begin
          m_phase  = 0;
          m_starve = 0;
        end else begin
          case (m_phase)
            0: begin
              m_acc = 0;
              m_ret = 0;
              if (DC_REQ && !(IC_REQ && m_starve == SM)) begin
                m_phase  = 1;
                m_d      = 1'b1;
                m_we     = DC_WE;
                m_base   = DC_ADDR & ~LMASK;
                m_starve = IC_REQ ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
              end else begin
                m_starve = 0;
                if (IC_REQ) begin
                  m_phase = 1;
                  m_d     = 1'b0;
                  m_we    = 1'b0;
                  m_base  = IC_ADDR & ~LMASK;
                end
              end
            end
            1: begin
              if (e_req && MEM_READY) m_acc++;
              if (!m_we && MEM_RVALID) m_ret++;
              if (m_we ? (m_acc == BL) : (m_ret == BL)) m_phase = 2;
            end
            default: m_phase = 0;
          endcase
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    acc_addr.delete();
    acc_wdata.delete();
    acc_widx.delete();
    acc_we_cnt  = 0;
    ic_rv_cnt   = 0;
    dc_rv_cnt   = 0;
    ic_done_cnt = 0;
    dc_done_cnt = 0;
    last_ic_rv_cyc = -100;
    ic_done_cyc    = -200;
    grant_log = "";
  endtask

  // Caches release their request on DONE unless told to keep it up.
  task automatic run(input int target, input int d_keep, input int i_keep, input int limit);
    int n  = 0;
    int dk = d_keep;
    int ik = i_keep;
    bit si, sd;
    while ((ic_done_cnt + dc_done_cnt) < target && n < limit) begin
      @(negedge CLK);
      si = IC_DONE;
      sd = DC_DONE;
      tick();
      n++;
      if (si) begin if (ik > 0) ik--; else IC_REQ = 1'b0; end
      if (sd) begin if (dk > 0) dk--; else DC_REQ = 1'b0; end
    end
    chk("run_within_budget", 32'(n < limit), 32'd1);
  endtask

  task automatic wait_accepts(input int cnt, input int limit);
    int n = 0;
    while (acc_addr.size() < cnt && n < limit) begin
      tick();
      n++;
    end
    chk("accept_wait_within_budget", 32'(n < limit), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_IC_GNT"}, IC_GNT, 0);
    chk({tag, "_IC_RVALID"}, IC_RVALID, 0);
    chk({tag, "_IC_RDATA"}, IC_RDATA, 0);
    chk({tag, "_IC_DONE"}, IC_DONE, 0);
    chk({tag, "_DC_GNT"}, DC_GNT, 0);
    chk({tag, "_DC_RVALID"}, DC_RVALID, 0);
    chk({tag, "_DC_RDATA"}, DC_RDATA, 0);
    chk({tag, "_DC_DONE"}, DC_DONE, 0);
    chk({tag, "_DC_WIDX"}, 32'(DC_WIDX), 0);
    chk({tag, "_MEM_REQ"}, MEM_REQ, 0);
    chk({tag, "_MEM_WE"}, MEM_WE, 0);
    chk({tag, "_MEM_ADDR"}, MEM_ADDR, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    RST = 1'b1; IC_REQ = 1'b0; DC_REQ = 1'b0; DC_WE = 1'b0;
    IC_ADDR = '0; DC_ADDR = '0;
    clear_logs();
    repeat (2) tick();
    mon_en = 1'b1;
    @(negedge CLK);
    chk_all_zero("reset");
    tick();
    RST = 1'b0;
    tick();

    // I refill, line 0x100, memory always ready, latency 2
    clear_logs();
    ready_mode = 0;
    IC_ADDR = 32'h0000_0104;
    IC_REQ  = 1'b1;
    run(1, 0, 0, 100);
    chk("t1_accepts", acc_addr.size(), 8);
    for (int k = 0; k < 8 && k < acc_addr.size(); k++)
      chk($sformatf("t1_addr%0d", k), acc_addr[k], 32'h100 + 32'(4 * k));
    chk("t1_ic_beats", ic_rv_cnt, 8);
    chk("t1_dc_beats", dc_rv_cnt, 0);
    chk("t1_done_after_last", ic_done_cyc - last_ic_rv_cyc, 1);
    chk("t1_grants", 32'(grant_log == "I"), 1);
    repeat (2) tick();

    // D writeback, line 0x2000, memory ready toggling
    clear_logs();
    ready_mode = 1;
    DC_WE   = 1'b1;
    DC_ADDR = 32'h0000_2000;
    DC_REQ  = 1'b1;
    run(1, 0, 0, 100);
    chk("t2_accepts", acc_addr.size(), 8);
    for (int k = 0; k < 8 && k < acc_addr.size(); k++) begin
      chk($sformatf("t2_addr%0d", k), acc_addr[k], 32'h2000 + 32'(4 * k));
      chk($sformatf("t2_widx%0d", k), 32'(acc_widx[k]), 32'(k));
      chk($sformatf("t2_wdata%0d", k), acc_wdata[k], 32'hCAFE_0000 + 32'(k));
    end
    chk("t2_writes", acc_we_cnt, 8);
    chk("t2_no_rvalid", ic_rv_cnt + dc_rv_cnt, 0);
    chk("t2_dc_done", dc_done_cnt, 1);
    chk("t2_ic_done", ic_done_cnt, 0);
    ready_mode = 0;
    DC_WE = 1'b0;
    repeat (2) tick();

    // Simultaneous requests: D first, then I
    clear_logs();
    IC_ADDR = 32'h0000_0300;
    DC_ADDR = 32'h0000_0400;
    IC_REQ  = 1'b1;
    DC_REQ  = 1'b1;
    run(2, 0, 0, 200);
    chk("t3_grants", 32'(grant_log == "DI"), 1);
    chk("t3_dc_beats", dc_rv_cnt, 8);
    chk("t3_ic_beats", ic_rv_cnt, 8);
    chk("t3_accepts", acc_addr.size(), 16);
    if (acc_addr.size() >= 9) begin
      chk("t3_first_d_addr", acc_addr[0], 32'h400);
      chk("t3_first_i_addr", acc_addr[8], 32'h300);
    end
    repeat (2) tick();

    // D kept busy while I waits: four D bursts, then I, then D again
    clear_logs();
    IC_ADDR = 32'h0000_0800;
    DC_ADDR = 32'h0000_0900;
    IC_REQ  = 1'b1;
    DC_REQ  = 1'b1;
    run(6, 99, 1, 600);
    IC_REQ = 1'b0;
    DC_REQ = 1'b0;
    chk("t4_grants", 32'(grant_log == "DDDDID"), 1);
    chk("t4_ic_done", ic_done_cnt, 1);
    chk("t4_dc_done", dc_done_cnt, 5);
    repeat (2) tick();

    // Reset during beat 3 of an I refill, then late read data
    clear_logs();
    IC_ADDR = 32'h0000_0500;
    IC_REQ  = 1'b1;
    wait_accepts(3, 50);
    RST    = 1'b1;
    IC_REQ = 1'b0;
    tick();
    RST     = 1'b0;
    spur_rv = 1'b1;
    @(negedge CLK);
    chk_all_zero("t5_after_rst");
    tick();
    @(negedge CLK);
    chk("t5_late_ic_rvalid", IC_RVALID, 0);
    chk("t5_late_ic_rdata", IC_RDATA, 0);
    tick();
    spur_rv = 1'b0;
    repeat (3) tick();
    chk("t5_no_ic_done", ic_done_cnt, 0);

    // Spurious read data while idle, then I request dropped mid-burst
    clear_logs();
    spur_rv = 1'b1;
    tick();
    @(negedge CLK);
    chk("t6_spur_ic_rvalid", IC_RVALID, 0);
    chk("t6_spur_dc_rvalid", DC_RVALID, 0);
    chk("t6_spur_ic_rdata", IC_RDATA, 0);
    chk("t6_spur_dc_rdata", DC_RDATA, 0);
    tick();
    spur_rv = 1'b0;
    IC_ADDR = 32'h0000_0600;
    IC_REQ  = 1'b1;
    wait_accepts(2, 50);
    IC_REQ = 1'b0;
    run(1, 0, 0, 100);
    chk("t6_ic_beats", ic_rv_cnt, 8);
    chk("t6_ic_done", ic_done_cnt, 1);
    chk("t6_grants", 32'(grant_log == "I"), 1);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
